// File: rtl/perceptron_pkg.sv
// Shared types and default sizing for the perceptron sequencer and its index counter.
package perceptron_pkg;

    localparam int unsigned DEF_N_IN   = 8;
    localparam int unsigned DEF_IDX_W  = 3;
    localparam int unsigned DEF_ACC_W  = 12;
    localparam int          DEF_THRESH = 0;
    localparam int unsigned ERR_CNT_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_WAIT,
        S_DECIDE,
        S_UPDATE,
        S_DONE
    } state_t;

endpackage

// File: rtl/perceptron_step_cnt.sv
// Weight index counter shared by the accumulate and update sweeps; done flags the last index.
module perceptron_step_cnt #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_en,
    output logic [W-1:0] o_idx,
    output logic         o_done
);

    logic [W-1:0] r_idx;

    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_idx <= '0;
        end else if (i_en) begin
            r_idx <= o_done ? '0 : r_idx + W'(1);
        end
    end

    assign o_idx  = r_idx;
    assign o_done = (r_idx == W'(N - 1));

endmodule

// File: rtl/perceptron_seq_ctrl.sv
// Perceptron sequencer: clear, accumulate, decide and optional +/-1 weight update per sample.
module perceptron_seq_ctrl
    import perceptron_pkg::*;
#(
    parameter int unsigned N_IN   = DEF_N_IN,
    parameter int unsigned IDX_W  = DEF_IDX_W,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int          THRESH = DEF_THRESH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_IN-1:0]      in_x,
    input  logic                 in_target,
    input  logic                 in_train,
    output logic                 dp_clr,
    output logic                 dp_acc_en,
    output logic                 dp_upd_en,
    output logic                 dp_upd_sign,
    output logic [IDX_W-1:0]     dp_idx,
    output logic                 dp_x,
    input  logic [ACC_W-1:0]     dp_sum,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_y,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 clr_stats,
    output logic                 busy
);

    localparam logic signed [ACC_W-1:0] THRESH_S = ACC_W'(THRESH);

    state_t                 r_state;
    logic [N_IN-1:0]        r_x;
    logic                   r_target;
    logic                   r_train;
    logic                   r_in_ready;
    logic                   r_busy;
    logic                   r_dp_clr;
    logic                   r_dp_acc_en;
    logic                   r_dp_upd_en;
    logic                   r_dp_upd_sign;
    logic [IDX_W-1:0]       r_dp_idx;
    logic                   r_dp_x;
    logic                   r_out_valid;
    logic                   r_out_y;
    logic                   r_out_err;
    logic [ERR_CNT_W-1:0]   r_err_cnt;

    logic                   w_cnt_run;
    logic [IDX_W-1:0]       w_idx;
    logic [IDX_W-1:0]       w_idx_nx;
    logic                   w_done;
    logic                   w_y;
    logic                   w_err;
    logic                   w_x_nx;

    // Counter sits at 0 outside the two sweeps so each sweep starts from index 0.
    assign w_cnt_run = (r_state == S_ACCUM) || (r_state == S_UPDATE);
    assign w_idx_nx  = w_idx + IDX_W'(1);
    assign w_x_nx    = r_x[w_idx_nx];
    assign w_y       = ($signed(dp_sum) >= THRESH_S);
    assign w_err     = w_y ^ r_target;

    perceptron_step_cnt #(
        .N (N_IN),
        .W (IDX_W)
    ) u_step_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (~w_cnt_run),
        .i_en   (w_cnt_run),
        .o_idx  (w_idx),
        .o_done (w_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_x           <= '0;
            r_target      <= 1'b0;
            r_train       <= 1'b0;
            r_in_ready    <= 1'b1;
            r_busy        <= 1'b0;
            r_dp_clr      <= 1'b0;
            r_dp_acc_en   <= 1'b0;
            r_dp_upd_en   <= 1'b0;
            r_dp_upd_sign <= 1'b0;
            r_dp_idx      <= '0;
            r_dp_x        <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_y       <= 1'b0;
            r_out_err     <= 1'b0;
            r_err_cnt     <= '0;
        end else begin
            // Strobes are single-cycle unless re-armed below for the next index.
            r_dp_clr      <= 1'b0;
            r_dp_acc_en   <= 1'b0;
            r_dp_upd_en   <= 1'b0;
            r_dp_upd_sign <= 1'b0;
            r_dp_idx      <= '0;
            r_dp_x        <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x        <= in_x;
                        r_target   <= in_target;
                        r_train    <= in_train;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_dp_clr   <= 1'b1;
                        r_state    <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_dp_acc_en <= 1'b1;
                    r_dp_x      <= r_x[0];
                    r_state     <= S_ACCUM;
                end
                S_ACCUM: begin
                    if (w_done) begin
                        r_state <= S_WAIT;
                    end else begin
                        r_dp_acc_en <= 1'b1;
                        r_dp_idx    <= w_idx_nx;
                        r_dp_x      <= w_x_nx;
                    end
                end
                S_WAIT: begin
                    r_state <= S_DECIDE;
                end
                S_DECIDE: begin
                    r_out_y   <= w_y;
                    r_out_err <= w_err;
                    if (r_train && w_err) begin
                        r_dp_upd_en   <= r_x[0];
                        r_dp_upd_sign <= r_x[0] & r_target;
                        r_dp_x        <= r_x[0];
                        if (r_err_cnt != '1) begin
                            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                        end
                        r_state <= S_UPDATE;
                    end else begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_UPDATE: begin
                    if (w_done) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_x_nx) begin
                        r_dp_upd_en   <= 1'b1;
                        r_dp_upd_sign <= r_target;
                        r_dp_idx      <= w_idx_nx;
                        r_dp_x        <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase

            // Clearing the statistics overrides a same-cycle increment.
            if (clr_stats) begin
                r_err_cnt <= '0;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign busy        = r_busy;
    assign dp_clr      = r_dp_clr;
    assign dp_acc_en   = r_dp_acc_en;
    assign dp_upd_en   = r_dp_upd_en;
    assign dp_upd_sign = r_dp_upd_sign;
    assign dp_idx      = r_dp_idx;
    assign dp_x        = r_dp_x;
    assign out_valid   = r_out_valid;
    assign out_y       = r_out_y;
    assign out_err     = r_out_err;
    assign err_cnt     = r_err_cnt;

endmodule

// File: doc/perceptron_seq_ctrl.md
Name: perceptron_seq_ctrl

Overview:
Sequencer for the perceptron datapath (shared weight store + signed accumulator) inside tt_um_perceptronOrig_mtchun. Accepts one binary input sample per handshake and steps the datapath one weight index per cycle through clear, accumulate, decide and optional weight update. Returns the classification, an error flag and a saturating training-error count. Sits between the ui_in/uio_in capture logic and the datapath.

Parameters:
N_IN, 8, number of perceptron inputs/weights
IDX_W, 3, width of weight index, equals clog2(N_IN)
ACC_W, 12, width of datapath signed sum
THRESH, 0, signed firing threshold; y = (dp_sum >= THRESH)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  sample offered
in_ready  out  1  controller can accept sample
in_x  in  N_IN  binary input vector
in_target  in  1  expected label
in_train  in  1  1 = train on error, 0 = inference only
dp_clr  out  1  clear datapath accumulator
dp_acc_en  out  1  accumulate w[dp_idx]*dp_x
dp_upd_en  out  1  update w[dp_idx] by ±1
dp_upd_sign  out  1  1 = increment, 0 = decrement
dp_idx  out  IDX_W  current weight index
dp_x  out  1  current input bit
dp_sum  in  ACC_W  signed accumulator value, registered, 1-cycle latency
out_valid  out  1  result available
out_ready  in  1  consumer takes result
out_y  out  1  classification
out_err  out  1  out_y != target
err_cnt  out  8  saturating count of training errors
clr_stats  in  1  clear err_cnt
busy  out  1  state != IDLE

Behaviour:
- Reset (rst high at posedge): state IDLE, in_ready=1, busy=0, all dp_* outputs 0, out_valid/out_y/out_err=0, err_cnt=0. Applies from any state, including mid-ACCUM/UPDATE; no datapath strobe is asserted in the cycle after reset.
- States: IDLE, CLEAR, ACCUM, WAIT, DECIDE, UPDATE, DONE.
- IDLE: in_ready=1. When in_valid is high, capture in_x, in_target, in_train, then go to CLEAR. in_ready=0 in every other state.
- CLEAR: dp_clr=1 for one cycle. Then ACCUM with idx=0.
- ACCUM: dp_acc_en=1, dp_idx=idx, dp_x=x[idx]. idx increments each cycle. After idx=N_IN-1, go to WAIT.
- WAIT: one idle cycle covering dp_sum latency.
- DECIDE: signed compare dp_sum >= THRESH gives y. err = y ^ target. Register out_y and out_err.
  - If train and err: go to UPDATE with idx=0.
  - Otherwise: go to DONE.
- UPDATE: steps idx 0..N_IN-1. dp_upd_en=x[idx], dp_upd_sign=target. After idx=N_IN-1, go to DONE.
- DONE: out_valid=1. out_y/out_err held stable until out_ready is high, then return to IDLE. in_valid is ignored while in DONE.
- err_cnt: increments by 1 on the DECIDE→UPDATE transition and saturates at 255. clr_stats clears it. If clr_stats and an increment occur in the same cycle, clear wins (result 0).
- Latency, counted from the accept edge (cycle 0):
  - out_valid first high at cycle N_IN+4 (12 for default).
  - Training with error: out_valid at 2·N_IN+4 (20).
- dp_idx and dp_x are 0 whenever dp_acc_en=0 and dp_upd_en=0.

Decomposition:
- perceptron_pkg: state enum, default N_IN/IDX_W/ACC_W localparams, err_cnt width constant.
- One sub-module: perceptron_step_cnt, a loadable index counter with done flag at N_IN-1. It is shared by ACCUM and UPDATE.

Test Plan:
- Reset: hold rst 2 cycles → in_ready=1, busy=0, out_valid=0, err_cnt=0, all dp_* = 0.
- Inference: bench model weights all +1, THRESH=0, in_x=8'h03, train=0 → dp_acc_en high cycles 2–9, out_valid at cycle 12, out_y=1, out_err=0, dp_upd_en never high.
- Training error: weights +1, THRESH=4, in_x=8'h0F, target=0, train=1 → sum=4, out_y=1, out_err=1; dp_upd_en high with sign=0 at idx 0–3 only (cycles 12–15), out_valid at cycle 20, err_cnt=1; model weights 0–3 now 0.
- Backpressure: out_ready low for 5 cycles after out_valid, in_valid held high → out_valid/out_y stable, in_ready=0. Raise out_ready → IDLE next cycle, new sample accepted.
- Reset mid-ACCUM: assert rst at cycle 5 → next cycle state IDLE, dp_acc_en=0, out_valid never asserted for that sample.
- err_cnt: 256 erring training samples → err_cnt=255 (saturated). Pulse clr_stats in the same cycle as a DECIDE→UPDATE transition → err_cnt=0.
